// File: rtl/lbm_stream_sequencer.sv
// lbm_stream_sequencer: row-major node sweep over a GRID_W x GRID_H D2Q9 lattice
// for n_steps time steps. Each node is presented with its nine streaming
// destinations and wall flags through a valid/ready handshake.
// Ports:
//   Clk, Reset         clock (rising edge), synchronous active-low reset
//   start              begin a run (sampled in IDLE only)
//   periodic_x         wrap in x (1) or bounce at side walls (0); latched on start
//   n_steps            steps to run; latched on start and clamped to MAX_TIME
//   out_ready          consumer accepts the current beat
//   out_valid          node beat valid
//   node_addr          y*GRID_W + x of the current node
//   stream_addr        direction i at [i*ADDRESS_WIDTH2 +: ADDRESS_WIDTH2]; MSB = bounce
//   LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL  boundary flags of the current node
//   time_count         0-based index of the current step
//   step_done, done    one-cycle pulses at end of step / end of run
//   busy               high from start acceptance until done
module lbm_stream_sequencer #(
    parameter int unsigned GRID_W           = 16,
    parameter int unsigned GRID_H           = 16,
    parameter int unsigned ADDRESS_WIDTH    = $clog2(GRID_W * GRID_H),
    parameter int unsigned ADDRESS_WIDTH2   = ADDRESS_WIDTH + 1,
    parameter int unsigned MAX_TIME         = 100,
    parameter int unsigned TIME_COUNT_WIDTH = $clog2(MAX_TIME)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic                          periodic_x,
    input  logic [TIME_COUNT_WIDTH:0]     n_steps,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [ADDRESS_WIDTH-1:0]      node_addr,
    output logic [9*ADDRESS_WIDTH2-1:0]   stream_addr,
    output logic                          LID,
    output logic                          BOTTOM_WALL,
    output logic                          LEFT_WALL,
    output logic                          RIGHT_WALL,
    output logic [TIME_COUNT_WIDTH:0]     time_count,
    output logic                          step_done,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned AW  = ADDRESS_WIDTH;
    localparam int unsigned AW2 = ADDRESS_WIDTH2;
    localparam int unsigned TW  = TIME_COUNT_WIDTH + 1;
    localparam int unsigned SW  = ADDRESS_WIDTH + 2;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_STEP_END = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic signed [SW-1:0] W_S = SW'(GRID_W);
    localparam logic signed [SW-1:0] H_S = SW'(GRID_H);
    localparam logic signed [SW-1:0] P1  = SW'(1);
    localparam logic signed [SW-1:0] M1  = {SW{1'b1}};

    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  x_q, x_d, y_q, y_d;
    logic [TW-1:0]  t_q, t_d, nsteps_q, nsteps_d, n_clamp_c;
    logic           per_q, per_d;

    logic           valid_q, valid_d;
    logic [AW-1:0]  node_q, node_d;
    logic [9*AW2-1:0] stream_q, stream_d;
    logic           lid_q, lid_d, bot_q, bot_d, left_q, left_d, right_q, right_d;
    logic           step_done_q, step_done_d, busy_q, busy_d, done_q, done_d;

    assign n_clamp_c = (n_steps > TW'(MAX_TIME)) ? TW'(MAX_TIME) : n_steps;

    // Linear address of an in-range node.
    function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] x, input logic [AW-1:0] y);
        return AW'({2'b00, y} * SW'(GRID_W) + {2'b00, x});
    endfunction

    // Streaming destination of (x,y) in direction dir; y bounce beats x wrap.
    function automatic logic [AW2-1:0] dest(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                            input logic per, input logic [3:0] dir);
        logic signed [SW-1:0] cx, cy, nx, ny;
        logic [AW2-1:0]       res;
        cx = '0;
        cy = '0;
        case (dir)
            4'd1:    begin cx = P1; cy = '0; end
            4'd2:    begin cx = '0; cy = P1; end
            4'd3:    begin cx = M1; cy = '0; end
            4'd4:    begin cx = '0; cy = M1; end
            4'd5:    begin cx = P1; cy = P1; end
            4'd6:    begin cx = M1; cy = P1; end
            4'd7:    begin cx = M1; cy = M1; end
            4'd8:    begin cx = P1; cy = M1; end
            default: begin cx = '0; cy = '0; end
        endcase
        nx = $signed({2'b00, x}) + cx;
        ny = $signed({2'b00, y}) + cy;
        if (ny < 0 || ny >= H_S) begin
            res = {1'b1, lin_addr(x, y)};
        end else if (nx < 0 || nx >= W_S) begin
            if (per) begin
                nx  = (nx < 0) ? (nx + W_S) : (nx - W_S);
                res = {1'b0, AW'(ny * W_S + nx)};
            end else begin
                res = {1'b1, lin_addr(x, y)};
            end
        end else begin
            res = {1'b0, AW'(ny * W_S + nx)};
        end
        return res;
    endfunction

    // Next-state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        t_d      = t_q;
        nsteps_d = nsteps_q;
        per_d    = per_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    per_d    = periodic_x;
                    nsteps_d = n_clamp_c;
                    t_d      = '0;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = (n_clamp_c == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // out_valid is always high here, so out_ready alone means accepted
                if (out_ready) begin
                    if (x_q == AW'(GRID_W - 1)) begin
                        x_d = '0;
                        if (y_q == AW'(GRID_H - 1)) begin
                            y_d     = '0;
                            state_d = S_STEP_END;
                        end else begin
                            y_d = y_q + AW'(1);
                        end
                    end else begin
                        x_d = x_q + AW'(1);
                    end
                end
            end
            S_STEP_END: begin
                t_d     = t_q + TW'(1);
                state_d = ((t_q + TW'(1)) == nsteps_q) ? S_DONE : S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d     = (state_d == S_RUN);
        step_done_d = (state_d == S_STEP_END);
        busy_d      = (state_d == S_RUN) || (state_d == S_STEP_END);
        done_d      = (state_d == S_DONE);
        node_d      = '0;
        stream_d    = '0;
        lid_d       = 1'b0;
        bot_d       = 1'b0;
        left_d      = 1'b0;
        right_d     = 1'b0;
        if (valid_d) begin
            node_d  = lin_addr(x_d, y_d);
            lid_d   = (y_d == AW'(GRID_H - 1));
            bot_d   = (y_d == '0);
            left_d  = (x_d == '0);
            right_d = (x_d == AW'(GRID_W - 1));
            for (int unsigned i = 0; i < 9; i++) begin
                stream_d[i*AW2 +: AW2] = dest(x_d, y_d, per_d, 4'(i));
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            nsteps_q    <= '0;
            per_q       <= 1'b0;
            valid_q     <= 1'b0;
            node_q      <= '0;
            stream_q    <= '0;
            lid_q       <= 1'b0;
            bot_q       <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t_q         <= t_d;
            nsteps_q    <= nsteps_d;
            per_q       <= per_d;
            valid_q     <= valid_d;
            node_q      <= node_d;
            stream_q    <= stream_d;
            lid_q       <= lid_d;
            bot_q       <= bot_d;
            left_q      <= left_d;
            right_q     <= right_d;
            step_done_q <= step_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid   = valid_q;
    assign node_addr   = node_q;
    assign stream_addr = stream_q;
    assign LID         = lid_q;
    assign BOTTOM_WALL = bot_q;
    assign LEFT_WALL   = left_q;
    assign RIGHT_WALL  = right_q;
    assign time_count  = t_q;
    assign step_done   = step_done_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
